// File: rtl/opb_register_simulink2ppc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : opb_register_simulink2ppc
// Purpose : OPB slave that publishes a fabric-generated 32-bit word to the
//           processor. Two words are visible in the slave window:
//             offset 0x00 DATA   (RO) last captured user_data_in
//             offset 0x04 STATUS      bit 0 NEW, bits 15:8 OVF (saturating)
//           Reading DATA clears NEW. Writing STATUS with any byte enable set
//           clears NEW and OVF.
// Ports   : OPB_Clk, OPB_Rst        clock / async active-high reset
//           OPB_ABus, OPB_BE,
//           OPB_DBus, OPB_RNW,
//           OPB_select, OPB_seqAddr OPB master request (big-endian numbering)
//           Sl_DBus, Sl_xferAck,
//           Sl_errAck, Sl_retry,
//           Sl_toutSup              OPB slave response
//           user_data_in,
//           user_data_valid         fabric word and its capture strobe
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01003600,
  parameter logic [31:0] C_HIGHADDR   = 32'h010036FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  input  logic [31:0] user_data_in,
  input  logic        user_data_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] data_reg;
  logic        new_flag;
  logic [7:0]  ovf_count;
  logic        ack_reg;
  logic [31:0] rdata_reg;

  logic        hit;
  logic        word_sel;
  logic        start;
  logic [31:0] status_word;
  logic [31:0] sel_word;
  logic        rd_data_clr;
  logic        wr_status_clr;

  // Write data, sequential-address hint and the informational parameters
  // carry no function in this slave.
  logic unused_ok;
  assign unused_ok = ^{OPB_DBus, OPB_seqAddr, (C_OPB_AWIDTH == 32),
                       (C_OPB_DWIDTH == 32), ^C_FAMILY};

  // OPB_ABus bit 0 is the MSB, so the vector's numeric value is the address.
  assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign word_sel = OPB_ABus[29];

  // A transfer starts only from IDLE; a select held through ACK/WAIT is
  // the same transfer and must not re-trigger side effects.
  assign start = (state == ST_IDLE) && hit;

  assign status_word = {16'h0000, ovf_count, 7'b0000000, new_flag};
  assign sel_word    = word_sel ? status_word : data_reg;

  assign rd_data_clr   = start && OPB_RNW && !word_sel;
  assign wr_status_clr = start && !OPB_RNW && word_sel && (|OPB_BE);

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (hit) state_next = ST_ACK;
      ST_ACK:  state_next = ST_WAIT;
      ST_WAIT: if (!OPB_select) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Ack and read data are registered at the hit edge, so both are valid for
  // exactly the ACK cycle and zero otherwise (wired-OR friendly).
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      ack_reg   <= 1'b0;
      rdata_reg <= 32'h0;
    end else begin
      ack_reg   <= start;
      rdata_reg <= (start && OPB_RNW) ? sel_word : 32'h0;
    end
  end

  // A fresh strobe always wins over a clear of NEW; a STATUS write clear
  // always wins over an OVF increment.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      data_reg  <= 32'h0;
      new_flag  <= 1'b0;
      ovf_count <= 8'h00;
    end else begin
      if (user_data_valid) begin
        data_reg <= user_data_in;
      end

      if (user_data_valid) begin
        new_flag <= 1'b1;
      end else if (rd_data_clr || wr_status_clr) begin
        new_flag <= 1'b0;
      end

      if (wr_status_clr) begin
        ovf_count <= 8'h00;
      end else if (user_data_valid && new_flag && (ovf_count != 8'hFF)) begin
        ovf_count <= ovf_count + 8'h01;
      end
    end
  end

  assign Sl_DBus    = rdata_reg;
  assign Sl_xferAck = ack_reg;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_opb_register_simulink2ppc
// Purpose : Self-checking bench for opb_register_simulink2ppc. A behavioural
//           model (data word, NEW flag, OVF count) predicts every bus read.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01003600;
  localparam logic [31:0] HIGH = 32'h010036FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] wdata;
  logic        rnw;
  logic        sel;
  logic        seqa;
  logic [0:31] sl_dbus;
  logic        sl_ack;
  logic        sl_err;
  logic        sl_retry;
  logic        sl_tout;
  logic [31:0] udata;
  logic        uvalid;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_data;
  bit          m_new;
  int          m_ovf;

  always #5 clk = ~clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst),
    .OPB_ABus       (abus),
    .OPB_BE         (be),
    .OPB_DBus       (wdata),
    .OPB_RNW        (rnw),
    .OPB_select     (sel),
    .OPB_seqAddr    (seqa),
    .Sl_DBus        (sl_dbus),
    .Sl_xferAck     (sl_ack),
    .Sl_errAck      (sl_err),
    .Sl_retry       (sl_retry),
    .Sl_toutSup     (sl_tout),
    .user_data_in   (udata),
    .user_data_valid(uvalid)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [7:0] o;
    o = m_ovf[7:0];
    return {16'h0000, o, 7'b0000000, m_new};
  endfunction

  task automatic m_valid(input logic [31:0] d);
    if (m_new && m_ovf < 255) m_ovf++;
    m_new  = 1'b1;
    m_data = d;
  endtask

  task automatic m_reset();
    m_data = 32'h0;
    m_new  = 1'b0;
    m_ovf  = 0;
  endtask

  // n consecutive one-cycle strobes
  task automatic valids(input int n, input bit rnd, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uvalid = 1'b1;
      udata  = rnd ? $urandom : d;
      m_valid(udata);
    end
    @(negedge clk);
    uvalid = 1'b0;
  endtask

  // One complete bus transfer at window byte offset 'off'; optionally a
  // user strobe lands on the same edge as the hit.
  task automatic xfer(input logic [7:0] off, input bit rd, input logic [3:0] bev,
                      input bit vsame, input logic [31:0] vd, input string tag,
                      output logic [31:0] got);
    logic [31:0] exp;
    bit          word;
    bit          clr_w;
    bit          clr_r;
    word  = off[2];
    exp   = rd ? (word ? m_status() : m_data) : 32'h0;
    clr_w = !rd && word && (bev != 4'h0);
    clr_r = rd && !word;
    @(negedge clk);
    abus  = BASE + {24'h0, off};
    rnw   = rd;
    be    = bev;
    wdata = $urandom;
    sel   = 1'b1;
    if (vsame) begin
      uvalid = 1'b1;
      udata  = vd;
    end
    @(posedge clk);
    #1;
    got = sl_dbus;
    check({tag, "_ack"}, {31'h0, sl_ack}, 32'h1);
    check({tag, "_dbus"}, sl_dbus, exp);
    sel    = 1'b0;
    uvalid = 1'b0;
    if (clr_w) begin
      m_new = 1'b0;
      m_ovf = 0;
    end
    if (vsame) m_valid(vd);
    else if (clr_r) m_new = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_ack_off"}, {31'h0, sl_ack}, 32'h0);
    check({tag, "_dbus_off"}, sl_dbus, 32'h0);
    @(posedge clk);
  endtask

  // Select held for n cycles at a fixed read address; counts acks.
  task automatic held(input logic [31:0] addr, input int n, input int exp_acks,
                      input string tag);
    int          acks;
    logic [31:0] expw;
    bit          inr;
    acks = 0;
    inr  = (addr >= BASE) && (addr <= HIGH);
    expw = addr[2] ? m_status() : m_data;
    @(negedge clk);
    abus = addr;
    rnw  = 1'b1;
    be   = 4'hF;
    sel  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sl_ack) begin
        acks++;
        check({tag, "_data"}, sl_dbus, expw);
      end else begin
        check({tag, "_quiet_bus"}, sl_dbus, 32'h0);
      end
    end
    sel = 1'b0;
    check({tag, "_acks"}, acks, exp_acks);
    if (inr && !addr[2] && acks > 0) m_new = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  off;
    int          op;
    abus = '0; be = '0; wdata = '0; rnw = 1'b0; sel = 1'b0; seqa = 1'b0;
    udata = '0; uvalid = 1'b0;
    m_reset();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_ack", {31'h0, sl_ack}, 32'h0);
    check("rst_dbus", sl_dbus, 32'h0);
    check("tied_low", {29'h0, sl_err, sl_retry, sl_tout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    xfer(8'h00, 1'b1, 4'hF, 1'b0, 0, "rst_data", r);
    xfer(8'h04, 1'b1, 4'hF, 1'b0, 0, "rst_status", r);

    // Capture then read DATA, then STATUS shows NEW cleared
    valids(1, 1'b0, 32'hDEADBEEF);
    xfer(8'h00, 1'b1, 4'hF, 1'b0, 0, "beef_read", r);
    check("beef_literal", r, 32'hDEADBEEF);
    xfer(8'h04, 1'b1, 4'hF, 1'b0, 0, "beef_status", r);
    check("beef_status_literal", r, 32'h00000000);

    // Overflow saturation
    valids(300, 1'b1, 0);
    xfer(8'h04, 1'b1, 4'hF, 1'b0, 0, "sat_status", r);
    check("sat_literal", r, 32'h0000FF01);

    // STATUS write clears; BE=0 write does nothing
    xfer(8'h04, 1'b0, 4'hF, 1'b0, 0, "clr_write", r);
    xfer(8'h04, 1'b1, 4'hF, 1'b0, 0, "clr_status", r);
    check("clr_literal", r, 32'h00000000);
    valids(2, 1'b1, 0);
    xfer(8'h04, 1'b0, 4'h0, 1'b0, 0, "be0_write", r);
    xfer(8'h00, 1'b0, 4'hF, 1'b0, 0, "data_write", r);
    xfer(8'h04, 1'b1, 4'hF, 1'b0, 0, "be0_status", r);
    check("be0_literal", r, 32'h00000101);

    // Strobe on the same edge as a DATA read
    xfer(8'h00, 1'b1, 4'hF, 1'b0, 0, "pre_clear", r);
    valids(1, 1'b0, 32'h00000001);
    xfer(8'h00, 1'b1, 4'hF, 1'b1, 32'h00000002, "coll_read", r);
    check("coll_old_value", r, 32'h00000001);
    xfer(8'h04, 1'b1, 4'hF, 1'b0, 0, "coll_status", r);
    check("coll_new_kept", {31'h0, r[0]}, 32'h1);
    xfer(8'h00, 1'b1, 4'hF, 1'b0, 0, "coll_next", r);
    check("coll_next_literal", r, 32'h00000002);

    // Strobe on the same edge as a STATUS clear
    valids(3, 1'b1, 0);
    xfer(8'h04, 1'b0, 4'hF, 1'b1, 32'h12345678, "coll_wr", r);
    xfer(8'h04, 1'b1, 4'hF, 1'b0, 0, "coll_wr_status", r);
    check("coll_wr_literal", r, 32'h00000001);

    // Address decode and held select
    held(32'h01003700, 5, 0, "above_win");
    held(32'h010035FC, 5, 0, "below_win");
    valids(2, 1'b1, 0);
    held(32'h01003604, 5, 1, "held_in");

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      op  = $urandom_range(0, 5);
      off = 8'($urandom_range(0, 255));
      case (op)
        0: valids($urandom_range(1, 3), 1'b1, 0);
        1: xfer(off, 1'b1, 4'hF, 1'b0, 0, "rnd_read", r);
        2: xfer(off, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 0, "rnd_write", r);
        3: begin
          off[2] = 1'b0;
          xfer(off, 1'b1, 4'hF, 1'b1, $urandom, "rnd_coll_rd", r);
        end
        4: begin
          off[2] = 1'b1;
          xfer(off, 1'b0, 4'($urandom_range(1, 15)), 1'b1, $urandom, "rnd_coll_wr", r);
        end
        default: begin
          off[2] = 1'b1;
          xfer(off, 1'b1, 4'hF, 1'b0, 0, "rnd_status", r);
        end
      endcase
    end

    // Reset asserted during ACK
    valids(1, 1'b0, 32'hA5A5F00D);
    @(negedge clk);
    abus = BASE;
    rnw  = 1'b1;
    be   = 4'hF;
    sel  = 1'b1;
    @(posedge clk);
    #1;
    check("rstack_ack_before", {31'h0, sl_ack}, 32'h1);
    check("rstack_dbus_before", sl_dbus, 32'hA5A5F00D);
    #1;
    rst = 1'b1;
    #1;
    check("rstack_ack_async", {31'h0, sl_ack}, 32'h0);
    check("rstack_dbus_async", sl_dbus, 32'h0);
    sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rstack_no_ack", {31'h0, sl_ack}, 32'h0);
    end
    xfer(8'h00, 1'b1, 4'hF, 1'b0, 0, "post_rst_data", r);
    check("post_rst_data_literal", r, 32'h0);
    xfer(8'h04, 1'b1, 4'hF, 1'b0, 0, "post_rst_status", r);
    check("post_rst_status_literal", r, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01003600, first byte address of the 256-byte slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010036FF, last byte address of the window.
REQ-003 SHALL have parameters C_OPB_AWIDTH, default 32, and C_OPB_DWIDTH, default 32, the bus widths; C_FAMILY, default "virtex5", target family (no functional effect).
REQ-004 SHALL have port OPB_Clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port OPB_Rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port OPB_ABus  in  [0:31]  byte address, bit 0 = MSB.
REQ-007 SHALL have ports OPB_BE in [0:3] byte enables; OPB_DBus in [0:31] write data; OPB_RNW in 1 (1=read); OPB_select in 1 transfer request; OPB_seqAddr in 1 (ignored).
REQ-008 SHALL have port Sl_DBus  out  [0:31]  read data; Sl_DBus[0] = register bit 31.
REQ-009 SHALL have ports Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  OPB slave responses.
REQ-010 SHALL have port user_data_in  in  [31:0]  fabric word to publish to the processor.
REQ-011 SHALL have port user_data_valid  in  1  one-cycle strobe capturing user_data_in.

Function
REQ-012 SHALL decode hit = OPB_select and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; offset = OPB_ABus[29] (word 0 or 1), other offset bits ignored.
REQ-013 SHALL map word 0 (offset 0x00) DATA, read-only: last captured user_data_in.
REQ-014 SHALL map word 1 (offset 0x04) STATUS: bit 0 NEW flag, bits 15:8 OVF count, all other bits read 0.
REQ-015 SHALL on user_data_valid load DATA <= user_data_in and set NEW on the next edge.
REQ-016 SHALL on user_data_valid while NEW=1 increment OVF, saturating at 255.
REQ-017 SHALL run bus FSM states IDLE, ACK, WAIT: IDLE->ACK on hit; ACK->WAIT unconditionally; WAIT->IDLE when OPB_select=0; IDLE holds otherwise.
REQ-018 SHALL assert Sl_xferAck exactly one cycle, in ACK (hit at edge N -> ack during cycle N+1).
REQ-019 SHALL in ACK drive Sl_DBus with the selected word as sampled at the hit edge if RNW=1, else all-zero; Sl_DBus SHALL be zero in every non-ACK cycle (wired-OR bus).
REQ-020 SHALL on a read of DATA clear NEW at the hit edge.
REQ-021 SHALL on a write to STATUS with any OPB_BE bit set clear NEW and OVF; writes to DATA or with OPB_BE=0 are acked and have no effect.
REQ-022 SHALL tie Sl_errAck, Sl_retry, Sl_toutSup to 0.
REQ-023 SHALL on simultaneous user_data_valid and DATA-read clear: NEW ends 1, DATA takes new value, returned read data is the old value, OVF increments if NEW was 1.
REQ-024 SHALL on simultaneous user_data_valid and STATUS-write clear: OVF ends 0, NEW ends 1, DATA takes new value.
REQ-025 SHALL not start a second transfer until WAIT exits; a hit held across ACK/WAIT is one transfer.

Reset
REQ-026 SHALL on OPB_Rst=1, immediately and independent of clock: DATA=0, NEW=0, OVF=0, FSM=IDLE, Sl_xferAck=0, Sl_DBus=0.
REQ-027 SHALL abandon a transfer in ACK or WAIT when reset asserts, with no ack after release until a new hit.

Verification
REQ-028 SHALL cover: valid with 32'hDEADBEEF, then read 0x01003600 -> xferAck one cycle after select, Sl_DBus=32'hDEADBEEF, subsequent STATUS read = 32'h00000000.
REQ-029 SHALL cover: 300 valid strobes with no reads -> STATUS = 32'h0000FF01 (OVF saturated, NEW set).
REQ-030 SHALL cover: write 32'h0 BE=4'hF to 0x01003604 after REQ-029 state -> STATUS reads 32'h00000000; write BE=4'h0 -> unchanged.
REQ-031 SHALL cover: valid 32'h00000002 in same cycle as DATA-read hit with old DATA 32'h00000001 -> read returns 1, NEW remains 1, next DATA read returns 2.
REQ-032 SHALL cover: address 0x01003700 with select held 5 cycles -> Sl_xferAck and Sl_DBus stay 0; in-range select held 5 cycles -> exactly one ack.
REQ-033 SHALL cover: OPB_Rst pulsed during ACK -> xferAck and Sl_DBus drop to 0 asynchronously, DATA/STATUS read 0 afterwards.
